// File: rtl/aes_pkg.sv
// aes_pkg: shared key-length encodings, schedule helper functions and FSM state type
package aes_pkg;
    localparam logic [1:0] AES_KL_128 = 2'd0;
    localparam logic [1:0] AES_KL_192 = 2'd1;
    localparam logic [1:0] AES_KL_256 = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EXPAND} ks_state_t;

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        return kl == AES_KL_128 ? 4'd4 : kl == AES_KL_192 ? 4'd6 : kl == AES_KL_256 ? 4'd8 : 4'd0;
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        return kl == AES_KL_128 ? 4'd10 : kl == AES_KL_192 ? 4'd12 : kl == AES_KL_256 ? 4'd14 : 4'd0;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box
module aes_sbox (
    input  logic [7:0] in,
    output logic [7:0] out
);
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign out = SBOX[{in, 3'b000} +: 8];
endmodule

// File: rtl/aes_key_schedule_seq.sv
// aes_key_schedule_seq: one-word-per-clock AES-128/192/256 key expansion into a round-key file
module aes_key_schedule_seq
    import aes_pkg::*;
#(
    parameter int MAX_NK = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [0:32*MAX_NK-1]  key_in,
    input  logic [3:0]            rk_rd_idx,
    output logic [0:127]          rk_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  key_valid,
    output logic                  err
);
    localparam int NR_MAX = MAX_NK + 6;
    localparam int IW = $clog2(MAX_NK);

    ks_state_t state, state_n;
    logic [3:0] nk_q, nr_q, m, nk_in;
    logic [5:0] i;
    logic [7:0] rcon;
    logic [31:0] win [0:MAX_NK-1];
    logic [0:127] rk [0:NR_MAX];
    logic accept, reject, bad_len, last;
    logic [31:0] oldest, sub_in, sub_out, temp, w_new;

    assign busy = state != ST_IDLE;

    // Start qualification and next-state selection
    always_comb begin
        nk_in = nk_of(key_len);
        bad_len = key_len == 2'd3 || nk_in > 4'(MAX_NK);
        accept = state == ST_IDLE && start && !bad_len;
        reject = state == ST_IDLE && start && bad_len;
        last = i == ({nr_q, 2'b00} + 6'd3);
        state_n = state == ST_IDLE ? (accept ? ST_LOAD : ST_IDLE) :
                  state == ST_LOAD ? ST_EXPAND : (last ? ST_IDLE : ST_EXPAND);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else state <= state_n;
    end

    // Next schedule word; win[0] is w[i-1], win[nk-1] is w[i-nk]
    always_comb begin
        oldest = win[IW'(nk_q - 4'd1)];
        sub_in = m == 4'd0 ? rot_word(win[0]) : win[0];
        temp = m == 4'd0 ? sub_out ^ {rcon, 24'h0} :
               (nk_q == 4'd8 && m == 4'd4) ? sub_out : win[0];
        w_new = oldest ^ temp;
    end

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.in(sub_in[8*b +: 8]), .out(sub_out[8*b +: 8]));
    end

    // Key latch, word generation, round-key file writes and registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            err <= 1'b0;
            key_valid <= 1'b0;
            nk_q <= '0;
            nr_q <= '0;
            m <= '0;
            i <= '0;
            rcon <= '0;
            rk_rd_data <= '0;
            for (int k = 0; k < MAX_NK; k++) win[k] <= '0;
            for (int k = 0; k <= NR_MAX; k++) rk[k] <= '0;
        end else begin
            done <= 1'b0;
            err <= reject;
            rk_rd_data <= rk_rd_idx > nr_q ? '0 : rk[rk_rd_idx];
            if (accept) begin
                nk_q <= nk_in;
                nr_q <= nr_of(key_len);
                key_valid <= 1'b0;
                for (int k = 0; k < MAX_NK; k++)
                    win[k] <= k < int'(nk_in) ? key_in[32*(int'(nk_in)-1-k) +: 32] : 32'h0;
            end
            if (state == ST_LOAD) begin
                for (int j = 0; j < MAX_NK; j++)
                    if (j < int'(nk_q)) rk[j/4][(j%4)*32 +: 32] <= win[IW'(int'(nk_q)-1-j)];
                i <= 6'(nk_q);
                m <= '0;
                rcon <= 8'h01;
            end
            if (state == ST_EXPAND) begin
                rk[i[5:2]][{i[1:0], 5'b00000} +: 32] <= w_new;
                win[0] <= w_new;
                for (int k = 1; k < MAX_NK; k++) win[k] <= win[k-1];
                i <= i + 6'd1;
                m <= m == nk_q - 4'd1 ? 4'd0 : m + 4'd1;
                if (m == 4'd0) rcon <= xtime(rcon);
                if (last) begin
                    done <= 1'b1;
                    key_valid <= 1'b1;
                end
            end
        end
    end
endmodule
